timer_dev: RTL



---
 rtl/timer_pkg.sv | 31 +++
 rtl/timer_dev_if.sv | 34 +++
 rtl/timer_dev.sv | 136 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// ============================================================================
// Module  : timer_pkg
// Brief   : Shared types and constants for the timer_dev countdown peripheral.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] C_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] C_ADDR_PRESET = 2'd1;
    localparam logic [1:0] C_ADDR_COUNT  = 2'd2;

    localparam int C_BIT_EN      = 0;
    localparam int C_BIT_MODE_LO = 1;
    localparam int C_BIT_MODE_HI = 2;
    localparam int C_BIT_IM      = 3;

    localparam logic [1:0] C_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] C_MODE_RELOAD  = 2'b01;

endpackage : timer_pkg

`default_nettype wire

// File: rtl/timer_dev_if.sv
// ============================================================================
// Module  : timer_dev_if
// Brief   : Processor-bridge register port of the timer peripheral.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_dev_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       addr;
    logic             we;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             irq;

    modport master (
        output addr,
        output we,
        output din,
        input  dout,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  din,
        output dout,
        output irq
    );
endinterface : timer_dev_if

`default_nettype wire

// File: rtl/timer_dev.sv
// ============================================================================
// Module  : timer_dev
// Brief   : Memory-mapped countdown timer with one-shot / auto-reload modes
//           and a maskable sticky interrupt. Macro TIMER_AUTORELOAD_EN enables
//           auto-reload for MODE 01.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_dev
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    timer_dev_if.slave  bus
);

    logic             r_en;
    logic [1:0]       r_mode;
    logic             r_im;
    logic [WIDTH-1:0] r_preset;
    logic [WIDTH-1:0] r_count;
    logic             r_pend;
    state_t           r_state;
    state_t           w_next;

    logic w_wr_ctrl;
    logic w_wr_preset;
    logic w_reload;
    logic w_load;
    logic w_dec;
    logic w_set_pend;
    logic w_hw_en_clr;

    assign w_wr_ctrl   = bus.we && (bus.addr == C_ADDR_CTRL);
    assign w_wr_preset = bus.we && (bus.addr == C_ADDR_PRESET);

`ifdef TIMER_AUTORELOAD_EN
    assign w_reload = (r_mode == C_MODE_RELOAD);
`else
    assign w_reload = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Clearing EN from software aborts any active phase; COUNT is left frozen.
    always_comb begin
        w_next = r_state;
        if (!r_en) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_next = ST_LOAD;
                ST_LOAD: w_next = ST_CNT;
                ST_CNT:  w_next = (r_count == '0) ? ST_INT : ST_CNT;
                ST_INT:  w_next = w_reload ? ST_LOAD : ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_set_pend  = 1'b0;
        w_hw_en_clr = 1'b0;
        if (r_en) begin
            case (r_state)
                ST_LOAD: w_load = 1'b1;
                ST_CNT: begin
                    w_dec      = (r_count != '0);
                    w_set_pend = (r_count == '0);
                end
                ST_INT:  w_hw_en_clr = !w_reload;
                default: ;
            endcase
        end
    end

    // The software CTRL write is ordered after the hardware EN clear so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_mode   <= C_MODE_ONESHOT;
            r_im     <= 1'b0;
            r_preset <= '0;
            r_count  <= '0;
            r_pend   <= 1'b0;
        end else begin
            if (w_hw_en_clr) begin
                r_en <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_en   <= bus.din[C_BIT_EN];
                r_mode <= bus.din[C_BIT_MODE_HI:C_BIT_MODE_LO];
                r_im   <= bus.din[C_BIT_IM];
            end
            if (w_wr_preset) begin
                r_preset <= bus.din;
            end
            if (w_load) begin
                r_count <= r_preset;
            end else if (w_dec) begin
                r_count <= r_count - 1'b1;
            end
            if (w_set_pend) begin
                r_pend <= 1'b1;
            end else if (w_wr_ctrl || w_wr_preset) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.dout = '0;
        case (bus.addr)
            C_ADDR_CTRL:   bus.dout = {{(WIDTH-4){1'b0}}, r_im, r_mode, r_en};
            C_ADDR_PRESET: bus.dout = r_preset;
            C_ADDR_COUNT:  bus.dout = r_count;
            default:       bus.dout = '0;
        endcase
    end

    assign bus.irq = r_pend & r_im;

endmodule : timer_dev

`default_nettype wire
